// File: rtl/bit_collector_sequential.sv
// Serial-to-parallel assembler. Bits are tagged with an index and arrive LSB first.
// The block rebuilds the vector, counts ones, and flags completion or an out-of-order index.
`timescale 1ns/1ps

module bit_collector_sequential #(
    parameter int WIDTH = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_valid,
    input  logic [IDX_W-1:0] bit_index,
    input  logic             bit_in,
    output logic             ready,
    output logic [IDX_W-1:0] expected_index,
    output logic [WIDTH-1:0] output_vector,
    output logic [IDX_W-1:0] ones_count,
    output logic             done,
    output logic             error
);

    // The index and count fields must be able to hold WIDTH.
    if ((2 ** IDX_W) <= WIDTH) begin : g_bad_params
        $error("bit_collector_sequential: IDX_W too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE,
        ERROR
    } state_t;

    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(WIDTH - 1);

    state_t state;

    logic             accept;
    logic             last_beat;
    logic [WIDTH-1:0] bit_mask;

    // The next three terms only prepare data. Every output below is still a flop.
    assign accept    = (state == COLLECT) && bit_valid && (bit_index == expected_index);
    assign last_beat = (expected_index == LAST_INDEX);
    assign bit_mask  = WIDTH'(bit_in) << expected_index;

    // NOTE: all state lives in one clocked block using non-blocking assignments only.
    // Every output is therefore registered, and no path runs from an input to an output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            output_vector  <= '0;
            ones_count     <= '0;
            expected_index <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
            ready          <= 1'b0;
        end else if (start) begin
            // Restart from any state. A beat presented in the same cycle is dropped.
            state          <= COLLECT;
            output_vector  <= '0;
            ones_count     <= '0;
            expected_index <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
            ready          <= 1'b1;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        // Unreceived bits are still zero, so an OR places the new bit.
                        output_vector <= output_vector | bit_mask;
                        ones_count    <= ones_count + IDX_W'(bit_in);
                        if (last_beat) begin
                            state <= DONE;
                            done  <= 1'b1;
                            ready <= 1'b0;
                        end else begin
                            expected_index <= expected_index + 1'b1;
                        end
                    end else if (bit_valid) begin
                        // Keep the partial vector, count and index frozen for debug.
                        state <= ERROR;
                        error <= 1'b1;
                        ready <= 1'b0;
                    end
                end
                default: ;  // IDLE, DONE and ERROR hold until the next start
            endcase
        end
    end

endmodule

// File: tb/tb_bit_collector_sequential.sv
// Self-checking bench for bit_collector_sequential. It runs directed scenarios and then random traffic.
// A queue-based reference model is checked against the DUT every cycle.
`timescale 1ns/1ps

module tb_bit_collector_sequential;

    localparam int WIDTH = 10;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             bit_valid = 1'b0;
    logic [IDX_W-1:0] bit_index = '0;
    logic             bit_in = 1'b0;
    logic             ready;
    logic [IDX_W-1:0] expected_index;
    logic [WIDTH-1:0] output_vector;
    logic [IDX_W-1:0] ones_count;
    logic             done;
    logic             error;

    int n_checks = 0;
    int n_fail   = 0;

    bit_collector_sequential #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bit_valid(bit_valid),
        .bit_index(bit_index),
        .bit_in(bit_in),
        .ready(ready),
        .expected_index(expected_index),
        .output_vector(output_vector),
        .ones_count(ones_count),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    // Reference model: the received bits in arrival order, plus a coarse mode.
    localparam int M_IDLE = 0, M_COLL = 1, M_DONE = 2, M_ERR = 3;
    bit q[$];
    int mode = M_IDLE;
    bit model_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            mode = M_IDLE;
            model_ok = 1'b1;
        end else if (start) begin
            q.delete();
            mode = M_COLL;
        end else if (mode == M_COLL && bit_valid) begin
            if (int'(bit_index) == q.size()) begin
                q.push_back(bit_in);
                if (q.size() == WIDTH) mode = M_DONE;
            end else begin
                mode = M_ERR;
            end
        end
    end

    function automatic logic [WIDTH-1:0] m_vec();
        logic [WIDTH-1:0] v = '0;
        foreach (q[i]) v[i] = q[i];
        return v;
    endfunction

    function automatic int m_ones();
        int n = 0;
        foreach (q[i]) n += int'(q[i]);
        return n;
    endfunction

    function automatic int m_exp();
        return (q.size() >= WIDTH) ? WIDTH - 1 : q.size();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // The compare process runs every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (model_ok) begin
            check("vector", 32'(output_vector), 32'(m_vec()));
            check("ones", 32'(ones_count), 32'(m_ones()));
            check("exp_idx", 32'(expected_index), 32'(m_exp()));
            check("done", 32'(done), 32'(mode == M_DONE));
            check("error", 32'(error), 32'(mode == M_ERR));
            check("ready", 32'(ready), 32'(mode == M_COLL));
        end
    end

    // Drive one cycle of inputs on the falling edge. The DUT samples them on the next rising edge.
    task automatic drive(input logic r, input logic s, input logic v,
                         input int idx, input logic b);
        @(negedge clk);
        rst = r;
        start = s;
        bit_valid = v;
        bit_index = IDX_W'(idx);
        bit_in = b;
    endtask

    task automatic idle(input int n = 1);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input int gap_after, input int gap_len);
        for (int i = 0; i < WIDTH; i++) begin
            drive(0, 0, 1, i, w[i]);
            if (i == gap_after) idle(gap_len);
        end
    endtask

    // Literal expectations, checked right after idle(). The outputs then show the previous cycle.
    task automatic pin(input string name, input logic [WIDTH-1:0] vec, input int ones,
                       input int exp, input logic d, input logic e, input logic rdy);
        check({name, ".vector"}, 32'(output_vector), 32'(vec));
        check({name, ".ones"}, 32'(ones_count), 32'(ones));
        check({name, ".exp_idx"}, 32'(expected_index), 32'(exp));
        check({name, ".done"}, 32'(done), 32'(d));
        check({name, ".error"}, 32'(error), 32'(e));
        check({name, ".ready"}, 32'(ready), 32'(rdy));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        drive(1, 0, 0, 0, 0);
        idle(1);
        pin("reset", '0, 0, 0, 0, 0, 0);

        // 1: full stream back-to-back
        drive(0, 1, 0, 0, 0);
        send_word(10'b1011001110, -1, 0);
        idle(1);
        pin("s1", 10'h2CE, 6, 9, 1, 0, 0);

        // 2: gap of three idle cycles between index 4 and index 5
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, i, logic'(i == 1 || i == 2 || i == 3));
        idle(1);
        check("s2.gap_exp", 32'(expected_index), 32'd5);
        idle(2);
        check("s2.gap_exp_hold", 32'(expected_index), 32'd5);
        for (int i = 5; i < WIDTH; i++) drive(0, 0, 1, i, logic'(i == 6 || i == 7 || i == 9));
        idle(1);
        pin("s2", 10'h2CE, 6, 9, 1, 0, 0);

        // 3: out-of-order index
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 1, 1, 1);
        drive(0, 0, 1, 3, 1);
        idle(1);
        pin("s3", 10'h003, 2, 2, 0, 1, 0);
        drive(0, 0, 1, 2, 1);
        idle(1);
        pin("s3.frozen", 10'h003, 2, 2, 0, 1, 0);

        // 4: restart after done, then all ones
        drive(0, 1, 0, 0, 0);
        send_word(10'b1011001110, -1, 0);
        drive(0, 1, 0, 0, 0);
        idle(1);
        pin("s4.cleared", '0, 0, 0, 0, 0, 1);
        send_word(10'h3FF, -1, 0);
        idle(1);
        pin("s4", 10'h3FF, 10, 9, 1, 0, 0);

        // 5: reset mid-collection with bit_valid held high
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, i, 1);
        drive(1, 0, 1, 5, 1);
        drive(0, 0, 1, 0, 1);
        pin("s5.reset", '0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 1);
        idle(1);
        pin("s5.ignored", '0, 0, 0, 0, 0, 0);

        // 6: start and a valid beat in the same cycle
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, i, 1);
        drive(0, 1, 1, 6, 1);
        idle(1);
        pin("s6", '0, 0, 0, 0, 0, 1);

        // Random traffic, mostly in-order with occasional wrong indices, starts and resets
        for (int c = 0; c < 3000; c++) begin
            logic r, s, v, b;
            int idx;
            r = ($urandom_range(199) == 0);
            s = (mode == M_COLL) ? ($urandom_range(39) == 0) : ($urandom_range(3) == 0);
            v = ($urandom_range(3) != 0);
            b = 1'($urandom);
            idx = ($urandom_range(11) == 0) ? int'($urandom_range(15)) : int'(q.size() % 16);
            drive(r, s, v, idx, b);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
